// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel 50% square output and tick strobe.
// Divisor writes land in a shadow register and commit only at a period boundary.
module clock_divider_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2,
    parameter int unsigned CH_W        = 2
) (
    input  logic              clkIn,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              syncAll,
    input  logic              divWr,
    input  logic [CH_W-1:0]   divCh,
    input  logic [CNT_W-1:0]  divVal,
    output logic [NUM_CH-1:0] clkOut,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] divPending
);

    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  r_act    [NUM_CH];
    logic [CNT_W-1:0]  r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_pend;

    logic [CNT_W-1:0]  w_cnt_nxt    [NUM_CH];
    logic [CNT_W-1:0]  w_act_nxt    [NUM_CH];
    logic [CNT_W-1:0]  w_shadow_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_eff        [NUM_CH];
    logic [NUM_CH-1:0] w_clk_nxt;
    logic [NUM_CH-1:0] w_tick_nxt;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [NUM_CH-1:0] w_term;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_commit;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // A stored divisor of 0 behaves as 1.
            w_eff[i]        = (r_act[i] == '0) ? CNT_W'(1) : r_act[i];
            w_term[i]       = (r_cnt[i] == (w_eff[i] - CNT_W'(1)));
            w_wr[i]         = divWr && (divCh == CH_W'(i));
            w_commit[i]     = !en[i] || syncAll || w_term[i];

            w_cnt_nxt[i]    = r_cnt[i];
            w_act_nxt[i]    = r_act[i];
            w_shadow_nxt[i] = r_shadow[i];
            w_clk_nxt[i]    = r_clk_out[i];
            w_tick_nxt[i]   = 1'b0;
            w_pend_nxt[i]   = r_pend[i];

            if (!en[i] || syncAll) begin
                w_cnt_nxt[i] = '0;
                w_clk_nxt[i] = 1'b0;
            end else if (w_term[i]) begin
                w_cnt_nxt[i]  = '0;
                w_clk_nxt[i]  = ~r_clk_out[i];
                w_tick_nxt[i] = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end

            // The commit uses the old shadow; a same-edge write stays pending for the next boundary.
            if (w_commit[i] && r_pend[i]) begin
                w_act_nxt[i]  = r_shadow[i];
                w_pend_nxt[i] = 1'b0;
            end
            if (w_wr[i]) begin
                w_shadow_nxt[i] = divVal;
                w_pend_nxt[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_act[i]    <= CNT_W'(DEFAULT_DIV);
                r_shadow[i] <= CNT_W'(DEFAULT_DIV);
            end
            r_clk_out <= '0;
            r_tick    <= '0;
            r_pend    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= w_cnt_nxt[i];
                r_act[i]    <= w_act_nxt[i];
                r_shadow[i] <= w_shadow_nxt[i];
            end
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            r_pend    <= w_pend_nxt;
        end
    end

    assign clkOut     = r_clk_out;
    assign tick       = r_tick;
    assign divPending = r_pend;

endmodule
